stage3_packet_head_parse_module: RTL
====================================

STAGE3_PACKET_HEAD_PARSE_MODULE -- requirements
Module: stage3_packet_head_parse_module

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_data  input  8  received packet byte.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_sop  input  1  in_data is the first byte of a packet; qualified by in_valid.
REQ-007 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 packet_seq_num_data  output  32  parsed sequence number, big-endian on the wire.
REQ-009 packet_messages_data  output  8  parsed message count.
REQ-010 head_valid  output  1  parsed header available; held until head_ready.
REQ-011 head_ready  input  1  downstream takes the header when head_valid && head_ready.
REQ-012 head_err  output  1  one-cycle pulse on a framing error.
REQ-013 seq_gap  output  1  one-cycle pulse on a sequence discontinuity (Configuration only).

Function
REQ-014 Header wire order SHALL be: `fast_SOH_data (1 byte), `fast_Version_Number_data (1 byte), seq num (4 bytes, MSB first), messages (1 byte); 7 bytes total.
REQ-015 FSM states SHALL be: IDLE, VER, SEQ, MSG, HOLD, DROP.
REQ-016 IDLE: an accepted byte with in_sop=1 and value `fast_SOH_data goes to VER; in_sop=1 with any other value pulses head_err and goes to DROP; in_sop=0 is discarded and the FSM stays in IDLE.
REQ-017 VER: a byte equal to `fast_Version_Number_data goes to SEQ with the 2-bit byte counter cleared; any other value pulses head_err and goes to DROP.
REQ-018 SEQ: each accepted byte shifts into the seq register (new byte enters the LSB); after the 4th byte, go to MSG.
REQ-019 MSG: the accepted byte loads packet_messages_data; next state is HOLD, with head_valid=1 from the following cycle.
REQ-020 Latency: head_valid SHALL assert in the cycle after the 7th header byte is accepted.
REQ-021 HOLD: in_ready=0, and outputs are stable while head_valid=1; on head_ready=1, head_valid drops next cycle and the FSM goes to IDLE.
REQ-022 in_ready SHALL be 1 in IDLE, VER, SEQ, MSG and DROP, and 0 in HOLD.
REQ-023 An accepted in_sop=1 byte in VER, SEQ, MSG or DROP SHALL abort the current packet and be treated as in IDLE in the same cycle; a mid-header abort (VER/SEQ/MSG) also pulses head_err.
REQ-024 DROP: bytes with in_sop=0 are discarded.
REQ-025 Bytes following a good header, up to the next in_sop, SHALL be discarded (payload is handled elsewhere); state after HOLD is IDLE.
REQ-026 When in_valid=0 in any state, the FSM and counters SHALL hold.
REQ-027 packet_seq_num_data and packet_messages_data SHALL update only when head_valid rises, and otherwise keep their last value.

Reset
REQ-028 On rst_n=0, the FSM SHALL go to IDLE immediately and the byte counter to 0.
REQ-029 On rst_n=0: packet_seq_num_data=0, packet_messages_data=0, head_valid=0, head_err=0, seq_gap=0, in_ready=0.
REQ-030 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.
REQ-031 A header in progress at reset SHALL be discarded and not reported.

Configuration
REQ-032 Macro PACKET_SEQ_GAP_CHECK_EN, when defined, SHALL add a 32-bit expected-sequence register plus a first-header flag, both cleared at reset.
REQ-033 With the macro, when head_valid rises and this is not the first header: if seq != expected, seq_gap pulses in the same cycle.
REQ-034 With the macro, the next expected value SHALL be seq + messages, mod 2^32; wrap from 0xFFFFFFFF SHALL be legal.
REQ-035 Without the macro, seq_gap SHALL be tied to 0 and the check logic SHALL be absent.

Verification
REQ-036 Bytes 01,01,00,00,00,2A,03 (sop on first) -> head_valid the next cycle, seq=0x0000002A, messages=0x03.
REQ-037 Hold head_ready=0 for 5 cycles -> in_ready=0 and outputs stable; head_ready=1 -> head_valid=0 next cycle, in_ready=1.
REQ-038 SOH byte 0x02 with sop -> head_err pulse, no head_valid; a following good header parses correctly.
REQ-039 in_sop asserted on the 4th byte -> head_err pulse, and that byte restarts parsing.
REQ-040 With the macro: seq 0xFFFFFFFF msgs 1, then seq 0x00000000 -> no seq_gap; next seq 0x00000005 -> seq_gap pulse.
REQ-041 Assert rst_n=0 during SEQ -> all outputs reset immediately; no head_valid after release.

Source files
------------

// File: rtl/stage3_packet_head_parse_module.sv
// stage3_packet_head_parse_module: parses the 7-byte packet header (SOH, version, 32-bit seq, message count).
// Define PACKET_SEQ_GAP_CHECK_EN to add sequence-discontinuity detection on seq_gap.
`ifndef fast_SOH_data
`define fast_SOH_data 8'h01
`endif
`ifndef fast_Version_Number_data
`define fast_Version_Number_data 8'h01
`endif
module stage3_packet_head_parse_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        in_ready,
  output logic [31:0] packet_seq_num_data,
  output logic [7:0]  packet_messages_data,
  output logic        head_valid,
  input  logic        head_ready,
  output logic        head_err,
  output logic        seq_gap
);
  typedef enum logic [2:0] {IDLE, VER, SEQ, MSG, HOLD, DROP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d, seq_q;
  logic [7:0]  msg_q;
  logic        rdy_q, err_q, err_d, acc, load;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      seq_q   <= '0;
      msg_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (load) begin
        seq_q <= shift_q;
        msg_q <= in_data;
      end
    end
  end
  // A start-of-packet byte restarts parsing from any state that accepts input.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    load    = 1'b0;
    if (state_q == HOLD) begin
      if (head_ready) state_d = IDLE;
    end else if (acc && in_sop) begin
      err_d   = (in_data != `fast_SOH_data) || (state_q inside {VER, SEQ, MSG});
      state_d = (in_data == `fast_SOH_data) ? VER : DROP;
    end else if (acc) begin
      case (state_q)
        VER: begin
          state_d = (in_data == `fast_Version_Number_data) ? SEQ : DROP;
          err_d   = in_data != `fast_Version_Number_data;
          cnt_d   = '0;
        end
        SEQ: begin
          shift_d = {shift_q[23:0], in_data};
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? MSG : SEQ;
        end
        MSG: begin
          state_d = HOLD;
          load    = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    in_ready             = rdy_q && (state_q != HOLD);
    head_valid           = state_q == HOLD;
    head_err             = err_q;
    packet_seq_num_data  = seq_q;
    packet_messages_data = msg_q;
  end
`ifdef PACKET_SEQ_GAP_CHECK_EN
  logic [31:0] exp_q;
  logic        seen_q, gap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      seen_q <= 1'b0;
      gap_q  <= 1'b0;
    end else begin
      gap_q <= load && seen_q && (shift_q != exp_q);
      if (load) begin
        exp_q  <= shift_q + {24'd0, in_data};
        seen_q <= 1'b1;
      end
    end
  end
  assign seq_gap = gap_q;
`else
  assign seq_gap = 1'b0;
`endif
endmodule
